// File: rtl/display_pkg.sv
// Constants, types and frame helpers shared by the display SPI host and slave.
package display_pkg;

    localparam logic [3:0] CMD_WRITE     = 4'b0001;
    localparam logic [3:0] ENABLE_REG    = 4'd0;
    localparam logic [3:0] RADIX_REG     = 4'd9;
    localparam int         NUM_REGISTERS = 10;
    localparam int         BYTE_WIDTH    = 8;
    localparam int         FRAME_W       = 16;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  point;
        logic [7:0]  enable;
    } snapshot_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SEND
    } sched_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_LEAD,
        T_LOW,
        T_HIGH,
        T_TAIL0,
        T_TAIL1,
        T_GAP
    } tx_state_t;

    // Register 0 carries the enables, 9 the radix points, 1..8 one digit nibble each.
    function automatic logic [BYTE_WIDTH-1:0] reg_data(input snapshot_t s, input logic [3:0] addr);
        logic [31:0] sh;
        sh = s.value >> {addr - 4'd1, 2'b00};
        case (addr)
            ENABLE_REG: reg_data = s.enable;
            RADIX_REG:  reg_data = s.point;
            default:    reg_data = {4'h0, sh[3:0]};
        endcase
    endfunction

    function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] addr,
                                                      input logic [BYTE_WIDTH-1:0] data);
        return {CMD_WRITE, addr, data};
    endfunction

endpackage

// File: rtl/display_spi_scheduler_frame_tx.sv
// Single 16-bit SPI write frame: lead-in, 16 bits MSB first, tail, inter-frame gap.
module spi_frame_tx
    import display_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic               block_clk_i,
    input  logic               rst_low_i,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               ready,
    output logic               commit,
    output logic               done,
    output logic               sclk,
    output logic               ss,
    output logic               mosi
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    tx_state_t          state, state_d;
    logic [15:0]        cnt, cnt_d;
    logic [FRAME_W-1:0] shreg, shreg_d;
    logic [3:0]         bit_cnt, bit_d;
    logic               div_end;

    assign div_end = (cnt == DIV_LAST);

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            state   <= T_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 16'd1;
        shreg_d = shreg;
        bit_d   = bit_cnt;
        commit  = 1'b0;
        done    = 1'b0;
        case (state)
            T_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = T_LEAD;
                    shreg_d = frame;
                    bit_d   = '0;
                end
            end
            T_LEAD: if (div_end) begin
                state_d = T_LOW;
                cnt_d   = '0;
            end
            T_LOW: if (div_end) begin
                state_d = T_HIGH;
                cnt_d   = '0;
            end
            T_HIGH: if (div_end) begin
                cnt_d = '0;
                if (bit_cnt == 4'd15) begin
                    state_d = T_TAIL0;
                end else begin
                    state_d = T_LOW;
                    shreg_d = {shreg[FRAME_W-2:0], 1'b0};
                    bit_d   = bit_cnt + 4'd1;
                end
            end
            T_TAIL0: if (div_end) begin
                state_d = T_TAIL1;
                cnt_d   = '0;
            end
            T_TAIL1: if (div_end) begin
                state_d = T_GAP;
                cnt_d   = '0;
                commit  = 1'b1;
            end
            T_GAP: if (cnt == GAP_LAST) begin
                state_d = T_IDLE;
                cnt_d   = '0;
                done    = 1'b1;
            end
            default: state_d = T_IDLE;
        endcase
    end

    // Pins decode straight from the state flops so reset forces idle levels at once.
    assign ready = (state == T_IDLE);
    assign sclk  = (state == T_IDLE) || (state == T_HIGH) || (state == T_GAP);
    assign ss    = !((state == T_LOW) || (state == T_HIGH) || (state == T_TAIL0));
    assign mosi  = ((state == T_LOW) || (state == T_HIGH)) ? shreg[FRAME_W-1] : 1'b1;

endmodule

// File: rtl/display_spi_scheduler.sv
// Sends only the display registers whose snapshot value differs from what the slave holds.
module display_spi_scheduler
    import display_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        block_clk_i,
    input  logic        rst_low_i,
    input  logic        update_i,
    input  logic [31:0] value_i,
    input  logic [7:0]  point_i,
    input  logic [7:0]  enable_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        spi_sclk_o,
    output logic        spi_ss_o,
    output logic        spi_mosi_o
);

    sched_state_t          state, state_d;
    snapshot_t             shadow;
    logic [3:0]            idx, idx_d;
    logic                  pending, clr_pending;
    logic [NUM_REGISTERS-1:0] sent_vld;
    logic [BYTE_WIDTH-1:0] sent_data [NUM_REGISTERS];
    logic [BYTE_WIDTH-1:0] cur_data, frm_data;
    logic [FRAME_W-1:0]    tx_frame;
    logic                  dirty, tx_start, tx_ready, tx_commit, tx_done;

    assign cur_data = reg_data(shadow, idx);
    assign dirty    = !sent_vld[idx] || (cur_data != sent_data[idx]);
    assign tx_frame = make_frame(idx, cur_data);
    assign busy_o   = (state != S_IDLE);

    // Later updates simply overwrite the shadow; one pending bit remembers a rescan is owed.
    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (update_i)
                shadow <= '{value: value_i, point: point_i, enable: enable_i};
            pending <= (pending && !clr_pending) || (update_i && (state != S_IDLE));
        end
    end

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            state    <= S_IDLE;
            idx      <= '0;
            frm_data <= '0;
            sent_vld <= '0;
            for (int i = 0; i < NUM_REGISTERS; i++)
                sent_data[i] <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (tx_start)
                frm_data <= cur_data;
            // Record the latched frame data, not the shadow, which may have moved on.
            if (tx_commit) begin
                sent_data[idx] <= frm_data;
                sent_vld[idx]  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        tx_start    = 1'b0;
        clr_pending = 1'b0;
        done_o      = 1'b0;
        case (state)
            S_IDLE: if (update_i || pending) begin
                state_d     = S_SCAN;
                idx_d       = '0;
                clr_pending = 1'b1;
            end
            S_SCAN: begin
                if (dirty && tx_ready) begin
                    tx_start = 1'b1;
                    state_d  = S_SEND;
                end else if (idx == RADIX_REG) begin
                    if (pending) begin
                        idx_d       = '0;
                        clr_pending = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_o  = 1'b1;
                    end
                end else begin
                    idx_d = idx + 4'd1;
                end
            end
            S_SEND: if (tx_done) begin
                // A frame for the last register ends the sweep without another scan slot.
                if (idx == RADIX_REG) begin
                    idx_d = '0;
                    if (pending) begin
                        state_d     = S_SCAN;
                        clr_pending = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_o  = 1'b1;
                    end
                end else begin
                    state_d = S_SCAN;
                    idx_d   = idx + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    spi_frame_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_tx (
        .block_clk_i (block_clk_i),
        .rst_low_i   (rst_low_i),
        .start       (tx_start),
        .frame       (tx_frame),
        .ready       (tx_ready),
        .commit      (tx_commit),
        .done        (tx_done),
        .sclk        (spi_sclk_o),
        .ss          (spi_ss_o),
        .mosi        (spi_mosi_o)
    );

endmodule

// File: tb/tb_display_spi_scheduler.sv
// Randomized bench for display_spi_scheduler against a register-level delta model.
module tb_display_spi_scheduler;
    import display_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;

    logic        clk = 1'b0, rst_n = 1'b0, update = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  point = '0, enable = '0;
    logic        busy, done, sclk, ss, mosi;

    int n_tests = 0, n_fail = 0;

    display_spi_scheduler #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .block_clk_i (clk),
        .rst_low_i   (rst_n),
        .update_i    (update),
        .value_i     (value),
        .point_i     (point),
        .enable_i    (enable),
        .busy_o      (busy),
        .done_o      (done),
        .spi_sclk_o  (sclk),
        .spi_ss_o    (ss),
        .spi_mosi_o  (mosi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what the slave holds, and the frames a sweep must produce.
    logic [7:0]  m_sent [10];
    bit          m_vld  [10];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    function automatic logic [7:0] rdata(input snapshot_t s, input int r);
        logic [31:0] t;
        if (r == 0) return s.enable;
        if (r == 9) return s.point;
        t = s.value >> (4 * (r - 1));
        return {4'h0, t[3:0]};
    endfunction

    function automatic bit m_dirty(input snapshot_t s, input int r);
        return !m_vld[r] || (rdata(s, r) != m_sent[r]);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 10; r++) m_vld[r] = 1'b0;
    endtask

    task automatic model_pass(input snapshot_t s, input int lo, input int hi);
        for (int r = lo; r <= hi; r++)
            if (m_dirty(s, r)) begin
                exp_q.push_back({4'h1, 4'(r), rdata(s, r)});
                m_sent[r] = rdata(s, r);
                m_vld[r]  = 1'b1;
            end
    endtask

    function automatic int count_dirty(input snapshot_t s);
        int n = 0;
        for (int r = 0; r < 10; r++) if (m_dirty(s, r)) n++;
        return n;
    endfunction

    function automatic int nth_dirty(input snapshot_t s, input int j);
        int n = 0;
        for (int r = 0; r < 10; r++)
            if (m_dirty(s, r)) begin
                if (n == j) return r;
                n++;
            end
        return 9;
    endfunction

    function automatic snapshot_t mutate(input snapshot_t s);
        snapshot_t o = s;
        if ($urandom_range(0, 2) == 0) o.enable = 8'($urandom);
        if ($urandom_range(0, 2) == 0) o.point  = 8'($urandom);
        for (int d = 0; d < 8; d++)
            if ($urandom_range(0, 4) == 0) o.value[4*d +: 4] = 4'($urandom);
        return o;
    endfunction

    // Bus monitor: protocol rules plus frame capture on every SCLK rise.
    int          cyc = 0, rise_cyc = 0, stable = 0, rises = 0, sfall_cnt = 0, done_cnt = 0;
    bit          have_rise = 1'b0;
    logic        p_sclk = 1'b1, p_ss = 1'b1, p_mosi = 1'b1;
    logic [15:0] shf = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_sclk = 1'b1; p_ss = 1'b1; p_mosi = 1'b1;
                stable = 0; rises = 0; have_rise = 1'b0;
            end else begin
                cyc++;
                if (ss !== p_ss) begin
                    chk("sclk_low_at_ss_edge", {30'd0, p_sclk, sclk}, 32'd0);
                    if (!ss) begin
                        sfall_cnt++;
                        if (have_rise) chk("gap_min", 32'((cyc - rise_cyc) >= GAP_CYCLES), 32'd1);
                        rises = 0;
                        shf   = '0;
                    end else begin
                        chk("rises_per_frame", rises, 32'd16);
                        got_q.push_back(shf);
                        rise_cyc  = cyc;
                        have_rise = 1'b1;
                    end
                end
                stable = (mosi !== p_mosi) ? 1 : stable + 1;
                if (!ss && sclk && !p_sclk) begin
                    rises++;
                    shf = {shf[14:0], mosi};
                    chk("mosi_setup", 32'(stable > CLK_DIV), 32'd1);
                end
                if (done) done_cnt++;
                p_sclk = sclk; p_ss = ss; p_mosi = mosi;
            end
        end
    end

    task automatic do_update(input snapshot_t s);
        @(negedge clk);
        value  = s.value;
        point  = s.point;
        enable = s.enable;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit ok);
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (busy) bc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // co: pulse snapshot sb during the j-th frame of sa's sweep.
    task automatic sweep(input snapshot_t sa, input bit co, input snapshot_t sb, input int j);
        int   f, nd, bc, rj;
        bit   ok;
        logic p;
        got_q.delete();
        exp_q.delete();
        nd = done_cnt;
        if (co) begin
            rj = nth_dirty(sa, j);
            model_pass(sa, 0, rj);
            model_pass(sb, rj + 1, 9);
            model_pass(sb, 0, 9);
        end else begin
            model_pass(sa, 0, 9);
        end
        do_update(sa);
        if (co) begin
            f = 0;
            p = ss;
            for (int i = 0; i < 20000 && f <= j; i++) begin
                @(negedge clk);
                if (p && !ss) f++;
                p = ss;
            end
            chk("coalesce_frame_seen", f, j + 1);
            repeat (CLK_DIV) @(negedge clk);
            do_update(sb);
        end
        wait_done(bc, ok);
        chk("done_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - nd, 32'd1);
        chk("busy_low_after", 32'(busy), 32'd0);
        chk("nframes", got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) chk("frame", 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        snapshot_t   a, b, prev;
        int          bc, f0, nd, nfr;
        bit          ok, co;
        logic [15:0] t1_exp [10];
        t1_exp = '{16'h10FF, 16'h1108, 16'h1207, 16'h1306, 16'h1405,
                   16'h1504, 16'h1603, 16'h1702, 16'h1801, 16'h1901};
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_ss",   32'(ss),   32'd1);
        chk("rst_mosi", 32'(mosi), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        a = '{value: 32'h12345678, point: 8'h01, enable: 8'hFF};
        sweep(a, 1'b0, a, 0);
        for (int i = 0; i < 10; i++)
            if (i < got_q.size()) chk("first_sweep_frame", 32'(got_q[i]), 32'(t1_exp[i]));

        a.value = 32'h12345679;
        sweep(a, 1'b0, a, 0);
        if (got_q.size() > 0) chk("delta_frame", 32'(got_q[0]), 32'h1109);

        f0 = sfall_cnt;
        nd = done_cnt;
        do_update(a);
        wait_done(bc, ok);
        chk("nochange_done_seen", 32'(ok), 32'd1);
        chk("nochange_busy_cycles", bc, 32'd10);
        repeat (3) @(negedge clk);
        chk("nochange_ss_falls", sfall_cnt - f0, 32'd0);
        chk("nochange_done_once", done_cnt - nd, 32'd1);

        b = a;
        b.value = 32'h87654321;
        do_update(b);
        for (int i = 0; i < 2000 && ss; i++) @(negedge clk);
        chk("midrst_frame_started", 32'(ss), 32'd0);
        repeat (16 * CLK_DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ss",   32'(ss),   32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd1);
        chk("midrst_mosi", 32'(mosi), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sweep(b, 1'b0, b, 0);
        chk("midrst_resend_all", got_q.size(), 32'd10);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        a = '{value: 32'h12345678, point: 8'h01, enable: 8'hFF};
        b = a;
        b.enable = 8'h0F;
        sweep(a, 1'b1, b, 1);
        chk("coalesce_nframes", got_q.size(), 32'd11);
        if (got_q.size() > 0) chk("coalesce_last", 32'(got_q[got_q.size()-1]), 32'h100F);

        prev = b;
        for (int it = 0; it < 15; it++) begin
            a   = mutate(prev);
            b   = mutate(a);
            nfr = count_dirty(a);
            co  = ($urandom_range(0, 1) == 1) && (nfr > 0);
            sweep(a, co, b, co ? int'($urandom_range(0, nfr - 1)) : 0);
            prev = co ? b : a;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_spi_scheduler.md
# display_spi_scheduler

Host-side controller for the Nexys4 seven-segment display SPI slave. It accepts a display snapshot of 8 hex digits, 8 radix points and 8 digit enables. It compares the snapshot against what the slave last received and sends only the changed registers as 16-bit write frames. Sits between the application logic and the display SPI slave, on the same block clock.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in block_clk_i cycles; minimum 2.
- GAP_CYCLES, 8: idle cycles after SS deasserts before the next frame; minimum 4, so the slave can register completion and clear its bit count.

Ports:
- block_clk_i  input  1  block clock; the only clock.
- rst_low_i  input  1  asynchronous, active-low reset.
- update_i  input  1  single-cycle request to sample the snapshot inputs.
- value_i  input  32  digit n (1..8) is value_i[4n-1:4n-4].
- point_i  input  8  radix markers, sent to slave register 9.
- enable_i  input  8  digit enables, sent to slave register 0.
- busy_o  output  1  high from the accepted update until the sweep completes.
- done_o  output  1  one-cycle pulse when a sweep completes.
- spi_sclk_o  output  1  idle high; the slave samples on the rising edge.
- spi_ss_o  output  1  idle high, active low.
- spi_mosi_o  output  1  idle high; MSB first.

## Operation
- Frame format: {4'b0001, addr[3:0], data[7:0]}, 16 bits, MSB first.
- Register 0: data = enable.
- Registers 1..8: data = {4'b0000, digit nibble}.
- Register 9: data = point.
- Snapshot: update_i in IDLE copies the inputs into shadow registers. busy_o goes high the next cycle.
- Coalescing: update_i while busy sets a pending flag and re-samples the shadow at once. Later updates overwrite earlier ones; only the latest snapshot is kept.
- Sent copy: a 10x8 register array holding what the slave last received. After reset every entry is marked invalid, so the first sweep sends all 10 registers.
- Dirty test per register: invalid, or shadow data differs from the sent copy.
- FSM states:
  - IDLE: on update_i, go to SCAN with idx=0.
  - SCAN: one cycle per idx. If the register is dirty, load the frame and go to LEAD. Otherwise increment idx. After idx=9:
    - if pending is set, clear it and restart SCAN at idx=0;
    - otherwise pulse done_o and go to IDLE.
  - LEAD: SCLK=0, SS=1 for CLK_DIV cycles. SCLK must be low before SS falls, because the slave gates SCLK with ~SS; a falling SS while SCLK is high would create a false sampling edge.
  - LOW: SS=0, SCLK=0, MOSI=current bit, CLK_DIV cycles.
  - HIGH: SCLK=1, CLK_DIV cycles; the rising edge is the sample point. After bit 15 go to TAIL, otherwise return to LOW with the next bit.
  - TAIL: SCLK=0 with SS=0 for CLK_DIV cycles, then SS=1 with SCLK=0 for CLK_DIV cycles.
  - GAP: SCLK=1, SS=1, MOSI=1 for GAP_CYCLES cycles. On entry, update the sent copy for idx and mark it valid. Then go to SCAN at idx+1.
- Sweep order: ascending address, 0 through 9.
- Sampling point: the dirty test uses the shadow as it stands when SCAN reaches that idx. Changes already sent are re-examined when the pending restart happens.

## Timing
- Reset values:
  - spi_sclk_o=1, spi_ss_o=1, spi_mosi_o=1;
  - busy_o=0, done_o=0;
  - state IDLE, pending=0, all sent entries invalid.
- Reset mid-frame: outputs return to idle levels immediately (asynchronous). The partial frame is abandoned and the slave discards it under the shared reset.
- Frame length: CLK_DIV + 32*CLK_DIV + 2*CLK_DIV + GAP_CYCLES cycles. With the defaults this is 148 cycles.
- Sweep cost: each clean register costs 1 SCAN cycle.
- MOSI changes only on SCLK falling edges or while SCLK is low. It is stable for CLK_DIV cycles before each rising edge.
- done_o fires in the cycle SCAN leaves idx 9 with no pending update. busy_o falls in the same cycle.
- Update with no changes: update_i in IDLE with an unchanged snapshot gives busy for 10 SCAN cycles, then done_o. No SS activity.
- update_i in the same cycle that done_o fires: treated as a new IDLE request the following cycle. It is not lost.

## Structure
- Shared package (display_pkg):
  - CMD_WRITE = 4'b0001;
  - ENABLE_REG = 0, RADIX_REG = 9, NUM_REGISTERS = 10;
  - BYTE_WIDTH = 8.
- The slave uses the same constants from display_pkg.
- Sub-module spi_frame_tx: a 16-bit shifter plus SCLK/SS sequencer implementing LEAD/LOW/HIGH/TAIL/GAP, with start/ready handshake.
- The scheduler keeps the shadow, sent copy, pending flag and SCAN FSM.

## Test plan
- Post-reset sweep: update_i with value_i=32'h12345678, point_i=8'h01, enable_i=8'hFF. Requires 10 frames, in this order:
  - 16'h10FF, then 16'h1108, 16'h1207 through 16'h1801 (digit 1 is the low nibble);
  - then 16'h1901;
  - one done_o pulse.
- Delta only: next update_i with value_i=32'h12345679. Requires exactly one frame, 16'h1109, then done_o.
- No change: repeat the identical update. Requires zero SS falling edges, done_o 10 cycles after busy_o rises.
- Coalesce: during frame 2 of the first test, pulse update_i with enable_i=8'h0F. Requires a restart sweep after idx 9 that sends 16'h100F, and a single done_o.
- SPI protocol check:
  - SCLK is low whenever SS changes;
  - exactly 16 rising edges per SS-low window;
  - MOSI stable ≥CLK_DIV cycles before each rise;
  - gap ≥GAP_CYCLES.
- Reset mid-frame: assert rst_low_i low after bit 7 of a frame. Requires SS=1, SCLK=1, MOSI=1 and busy_o=0 immediately. The next update sends all 10 registers.
